// File: rtl/bg1_shift_sequencer.sv
// BG1 shift ROM read client: requests one lifting-set vector, captures it,
// reduces each entry mod Zc and streams the results over a valid/ready link.
// Ports: clk, reset_n (sync, active-low); start/ils_sel/zc request;
//   rd_en1/ils_selected/bg1_in/bg1_valid ROM side;
//   shift_out/shift_idx/shift_valid/shift_ready stream; busy/done/err status.
// Optional: define BG1_SEQ_TIMEOUT_EN to abort WAIT after 16 idle cycles.
module bg1_shift_sequencer #(
  parameter int NUM_ENTRIES = 316,
  parameter int SHIFT_W     = 9,
  parameter int IDX_W       = 9
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start,
  input  logic [2:0]                             ils_sel,
  input  logic [SHIFT_W-1:0]                     zc,
  output logic                                   rd_en1,
  output logic [2:0]                             ils_selected,
  input  logic [NUM_ENTRIES-1:0][SHIFT_W-1:0]    bg1_in,
  input  logic                                   bg1_valid,
  output logic [SHIFT_W-1:0]                     shift_out,
  output logic [IDX_W-1:0]                       shift_idx,
  output logic                                   shift_valid,
  input  logic                                   shift_ready,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_STREAM
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  state_t state, state_n;

  logic [NUM_ENTRIES-1:0][SHIFT_W-1:0] cap, cap_n;
  logic [SHIFT_W-1:0] zc_r, zc_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               last_r, last_n;
  logic               rd_en1_n;
  logic [2:0]         ils_n;
  logic [SHIFT_W-1:0] out_n;
  logic [IDX_W-1:0]   sidx_n;
  logic               valid_n, done_n, err_n;
  logic [SHIFT_W-1:0] raw, red;

`ifdef BG1_SEQ_TIMEOUT_EN
  logic [4:0] wcnt, wcnt_n;
`endif

  // Table entries are always below 2*Zc, so one conditional subtract
  // is a full modulo reduction.
  assign raw  = cap[idx];
  assign red  = (raw >= zc_r) ? raw - zc_r : raw;
  assign busy = (state != S_IDLE) | done;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    cap_n    = cap;
    zc_n     = zc_r;
    idx_n    = idx;
    last_n   = last_r;
    ils_n    = ils_selected;
    out_n    = shift_out;
    sidx_n   = shift_idx;
    valid_n  = shift_valid;
    rd_en1_n = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
`ifdef BG1_SEQ_TIMEOUT_EN
    wcnt_n   = wcnt;
`endif
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (zc != '0) begin
            ils_n    = ils_sel;
            zc_n     = zc;
            rd_en1_n = 1'b1;
            state_n  = S_REQ;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_REQ: begin
        state_n = S_WAIT;
`ifdef BG1_SEQ_TIMEOUT_EN
        wcnt_n  = '0;
`endif
      end
      S_WAIT: begin
        if (bg1_valid) begin
          cap_n   = bg1_in;
          idx_n   = '0;
          last_n  = 1'b0;
          state_n = S_STREAM;
        end
`ifdef BG1_SEQ_TIMEOUT_EN
        else if (wcnt == 5'd15) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          wcnt_n = wcnt + 5'd1;
        end
`endif
      end
      S_STREAM: begin
        // last_r marks that the beat on the output is the final one.
        if (shift_valid && shift_ready && last_r) begin
          valid_n = 1'b0;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else if ((!shift_valid || shift_ready) && !last_r) begin
          out_n   = red;
          sidx_n  = idx;
          valid_n = 1'b1;
          last_n  = (idx == LAST_IDX);
          if (idx != LAST_IDX) idx_n = idx + IDX_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap          <= '0;
      zc_r         <= '0;
      idx          <= '0;
      last_r       <= 1'b0;
      rd_en1       <= 1'b0;
      ils_selected <= '0;
      shift_out    <= '0;
      shift_idx    <= '0;
      shift_valid  <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      cap          <= cap_n;
      zc_r         <= zc_n;
      idx          <= idx_n;
      last_r       <= last_n;
      rd_en1       <= rd_en1_n;
      ils_selected <= ils_n;
      shift_out    <= out_n;
      shift_idx    <= sidx_n;
      shift_valid  <= valid_n;
      done         <= done_n;
      err          <= err_n;
    end
  end

`ifdef BG1_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) wcnt <= '0;
    else          wcnt <= wcnt_n;
  end
`endif

endmodule

// File: tb/tb_bg1_shift_sequencer.sv
// Scoreboard bench for bg1_shift_sequencer: directed sequences with a
// simple ROM model, backpressure, zc=0 error, mid-stream reset, WAIT hold.
module tb_bg1_shift_sequencer;

  localparam int N  = 316;
  localparam int SW = 9;
  localparam int IW = 9;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [2:0]         ils_sel = '0;
  logic [SW-1:0]      zc = '0;
  logic               rd_en1;
  logic [2:0]         ils_selected;
  logic [N-1:0][SW-1:0] rom_bus = '0;
  logic               bg1_valid = 1'b0;
  logic [SW-1:0]      shift_out;
  logic [IW-1:0]      shift_idx;
  logic               shift_valid;
  logic               shift_ready = 1'b1;
  logic               busy, done, err;

  bg1_shift_sequencer #(.NUM_ENTRIES(N), .SHIFT_W(SW), .IDX_W(IW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ils_sel(ils_sel),
    .zc(zc), .rd_en1(rd_en1), .ils_selected(ils_selected),
    .bg1_in(rom_bus), .bg1_valid(bg1_valid), .shift_out(shift_out),
    .shift_idx(shift_idx), .shift_valid(shift_valid),
    .shift_ready(shift_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int val;
  } beat_t;

  beat_t sb[$];
  int    exp_v[N];
  int    n_tests = 0;
  int    n_fail = 0;
  int    beats = 0;
  int    done_cnt = 0;
  int    rd_cnt = 0;
  int    err_cnt = 0;
  bit    rom_en = 1'b0;

  function automatic void check(string nm, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endfunction

  // ROM model: valid for one cycle, the cycle after rd_en1 was high.
  initial begin
    bit r;
    forever begin
      @(negedge clk);
      r = rd_en1;
      @(posedge clk);
      #1;
      bg1_valid = r && rom_en;
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks stall holds.
  initial begin
    bit   stalled = 1'b0;
    int   p_idx = 0;
    int   p_out = 0;
    beat_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stalled = 1'b0;
      end else begin
        if (done)   done_cnt++;
        if (rd_en1) rd_cnt++;
        if (err)    err_cnt++;
        if (stalled) begin
          check("stall_valid", int'(shift_valid), 1);
          check("stall_idx", int'(shift_idx), p_idx);
          check("stall_out", int'(shift_out), p_out);
        end
        if (shift_valid && shift_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_beat", int'(shift_idx), -1);
          end else begin
            e = sb.pop_front();
            check("beat_idx", int'(shift_idx), e.idx);
            check("beat_out", int'(shift_out), e.val);
          end
          beats++;
        end
        stalled = shift_valid && !shift_ready;
        p_idx   = int'(shift_idx);
        p_out   = int'(shift_out);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp();
    beat_t b;
    sb.delete();
    for (int i = 0; i < N; i++) begin
      b.idx = i;
      b.val = exp_v[i];
      sb.push_back(b);
    end
  endtask

  task automatic run_seq(input int ils, input int zcv, input bit bp,
                         input bit again);
    int  cyc;
    int  stall;
    bit  sent;
    push_exp();
    rom_en   = 1'b1;
    beats    = 0;
    done_cnt = 0;
    rd_cnt   = 0;
    err_cnt  = 0;
    stall    = 0;
    sent     = 1'b0;
    ils_sel  = 3'(ils);
    zc       = SW'(zcv);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    ils_sel  = 3'd5;
    zc       = 9'd7;
    check("busy_after_start", int'(busy), 1);
    check("rd_en1_in_req", int'(rd_en1), 1);
    check("ils_selected", int'(ils_selected), ils);
    tick();
    check("rd_en1_low_wait", int'(rd_en1), 0);
    check("ils_selected_wait", int'(ils_selected), ils);
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      if (start) begin
        start = 1'b0;
      end else if (again && !sent && shift_valid && shift_idx > 20) begin
        start = 1'b1;
        zc    = '0;
        sent  = 1'b1;
      end
      if (bp) begin
        if (shift_valid && shift_idx == 10 && stall < 5) begin
          shift_ready = 1'b0;
          stall++;
        end else if (stall >= 5) begin
          shift_ready = 1'($urandom_range(0, 1));
        end else begin
          shift_ready = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    start       = 1'b0;
    shift_ready = 1'b1;
    check("done_pulses", done_cnt, 1);
    check("rd_en1_cycles", rd_cnt, 1);
    check("beat_count", beats, N);
    check("sb_empty", sb.size(), 0);
    check("no_err", err_cnt, 0);
    tick();
    check("busy_after_done", int'(busy), 0);
    check("done_single", done_cnt, 1);
  endtask

  initial begin
    int c;
    // Reset state
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_rd_en1", int'(rd_en1), 0);
    check("rst_valid", int'(shift_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_ils", int'(ils_selected), 0);
    reset_n = 1'b1;
    tick();

    // Sequence 1: zc=384, raw values below zc pass through unchanged
    for (int i = 0; i < N; i++) begin
      rom_bus[i] = SW'((i * 37 + 11) % 384);
      exp_v[i]   = (i * 37 + 11) % 384;
    end
    run_seq(2, 384, 1'b0, 1'b0);

    // Sequence 2: zc=208, backpressure, ignored start during STREAM
    for (int i = 0; i < N; i++) begin
      rom_bus[i] = SW'((i * 53 + 3) % 416);
      exp_v[i]   = ((i * 53 + 3) % 416) % 208;
    end
    rom_bus[0] = 9'd307;
    rom_bus[1] = 9'd208;
    rom_bus[2] = 9'd5;
    exp_v[0]   = 99;
    exp_v[1]   = 0;
    exp_v[2]   = 5;
    run_seq(4, 208, 1'b1, 1'b1);

    // zc=0 start: error pulse only
    zc    = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zc0_err", int'(err), 1);
    check("zc0_rd_en1", int'(rd_en1), 0);
    check("zc0_busy", int'(busy), 0);
    tick();
    check("zc0_err_clear", int'(err), 0);
    check("zc0_busy_after", int'(busy), 0);
    check("zc0_rd_after", int'(rd_en1), 0);

    // Reset in the middle of STREAM
    for (int i = 0; i < N; i++) begin
      rom_bus[i] = SW'((i * 37 + 11) % 384);
      exp_v[i]   = (i * 37 + 11) % 384;
    end
    push_exp();
    rom_en   = 1'b1;
    beats    = 0;
    done_cnt = 0;
    ils_sel  = 3'd1;
    zc       = 9'd384;
    start    = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (beats < 50 && c < 500) begin
      tick();
      c++;
    end
    check("mid_reach50", beats, 50);
    reset_n = 1'b0;
    tick();
    check("mid_rst_valid", int'(shift_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_out", int'(shift_out), 0);
    check("mid_rst_idx", int'(shift_idx), 0);
    check("mid_rst_ils", int'(ils_selected), 0);
    check("mid_rst_flags", int'({rd_en1, done, err}), 0);
    reset_n = 1'b1;
    sb.delete();
    tick();
    check("mid_no_done", done_cnt, 0);
    run_seq(7, 384, 1'b0, 1'b0);

    // ROM never answers
    rom_en  = 1'b0;
    err_cnt = 0;
    zc      = 9'd100;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
`ifdef BG1_SEQ_TIMEOUT_EN
    c = 0;
    while (!err && c < 40) begin
      tick();
      c++;
    end
    check("timeout_cycles", c, 16);
    check("timeout_busy", int'(busy), 0);
    check("timeout_done", int'(done), 0);
    tick();
    check("timeout_err_pulse", int'(err), 0);
`else
    repeat (100) tick();
    check("hold_busy", int'(busy), 1);
    check("hold_rd_en1", int'(rd_en1), 0);
    check("hold_valid", int'(shift_valid), 0);
    check("hold_no_err", err_cnt, 0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("hold_recover", int'(busy), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
